// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the RO-PUF measurement engine.
// Holds the FSM encoding, mode codes and the Galois LFSR step.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StMeasure,
        StDecide,
        StDone
    } state_e;

    localparam logic MODE_RACE   = 1'b0;
    localparam logic MODE_WINDOW = 1'b1;

    localparam int unsigned SETTLE_CYC = 3;

    // Right-shifting Galois step; callers zero-extend to 32 bits and truncate the result back.
    function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input logic [31:0] tap);
        return (cur >> 1) ^ (cur[0] ? tap : 32'd0);
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises one asynchronous RO output and counts its rising edges.
// The counter saturates at all-ones and is held at zero while clr_i is high.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             cnt_en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && sync2_q && !prev_q && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == CntMax);

endmodule

// File: rtl/ro_puf_engine.sv
// Serial RO-PUF engine: LFSR-scrambled RO pair selection, edge racing or windowed
// counting, and a shift register collecting one comparison bit per LFSR step.
module ro_puf_engine
    import ro_puf_pkg::*;
#(
    parameter int unsigned       N_RO     = 16,
    parameter int unsigned       CHAL_W   = 8,
    parameter int unsigned       RESP_W   = 8,
    parameter int unsigned       CNT_W    = 8,
    parameter int unsigned       WIN_CYC  = 255,
    parameter logic [CHAL_W-1:0] LFSR_TAP = 8'hB8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [CHAL_W-1:0] chall_in_i,
    input  logic [N_RO-1:0]   ro_in_i,
    output logic              ro_en_o,
    output logic              busy_o,
    output logic              ready_o,
    output logic [RESP_W-1:0] response_o,
    output logic              tie_o
);

    localparam int unsigned HALF  = N_RO / 2;
    localparam int unsigned SEL_W = $clog2(HALF);
    localparam int unsigned TMR_W = $clog2(WIN_CYC + 1);
    localparam int unsigned IDX_W = $clog2(RESP_W + 1);

    localparam logic [TMR_W-1:0] TmrLast    = TMR_W'(WIN_CYC - 1);
    localparam logic [IDX_W-1:0] IdxLast    = IDX_W'(RESP_W - 1);
    localparam logic [1:0]       SettleLast = 2'(SETTLE_CYC - 1);

    state_e            state_q, state_d;
    logic [CHAL_W-1:0] lfsr_q, lfsr_d;
    logic              mode_q, mode_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              tie_q, tie_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [1:0]        settle_q, settle_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [HALF-1:0]  bank_a, bank_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             ro_a, ro_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             sat_a, sat_b;
    logic             cnt_clr, cnt_en, bit_val;

    assign bank_a  = ro_in_i[HALF-1:0];
    assign bank_b  = ro_in_i[N_RO-1:HALF];
    assign sel_a   = lfsr_q[SEL_W-1:0];
    assign sel_b   = lfsr_q[CHAL_W-1 -: SEL_W];
    assign ro_a    = bank_a[sel_a];
    assign ro_b    = bank_b[sel_b];
    assign cnt_clr = (state_q == StSettle);
    assign cnt_en  = (state_q == StMeasure);
    assign bit_val = (cnt_a > cnt_b);

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ro_i     (ro_a),
        .clr_i    (cnt_clr),
        .cnt_en_i (cnt_en),
        .cnt_o    (cnt_a),
        .sat_o    (sat_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ro_i     (ro_b),
        .clr_i    (cnt_clr),
        .cnt_en_i (cnt_en),
        .cnt_o    (cnt_b),
        .sat_o    (sat_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            lfsr_q   <= '0;
            mode_q   <= MODE_RACE;
            resp_q   <= '0;
            tie_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            settle_q <= '0;
            tmr_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            mode_q   <= mode_d;
            resp_q   <= resp_d;
            tie_q    <= tie_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            settle_q <= settle_d;
            tmr_q    <= tmr_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        mode_d   = mode_q;
        resp_d   = resp_q;
        tie_d    = tie_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        settle_d = settle_q;
        tmr_d    = tmr_q;
        idx_d    = idx_q;
        if (!en_i) begin
            // Abort discards any partial or finished result.
            if (state_q != StIdle) begin
                state_d = StIdle;
                ready_d = 1'b0;
                busy_d  = 1'b0;
                resp_d  = '0;
                tie_d   = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d  = StSettle;
                        lfsr_d   = (chall_in_i == '0) ? CHAL_W'(1) : chall_in_i;
                        mode_d   = mode_i;
                        resp_d   = '0;
                        tie_d    = 1'b0;
                        idx_d    = '0;
                        ready_d  = 1'b0;
                        busy_d   = 1'b1;
                        settle_d = '0;
                    end
                end
                StSettle: begin
                    tmr_d    = '0;
                    settle_d = settle_q + 1'b1;
                    if (settle_q == SettleLast) state_d = StMeasure;
                end
                StMeasure: begin
                    tmr_d = tmr_q + 1'b1;
                    if ((tmr_q == TmrLast) || ((mode_q == MODE_RACE) && (sat_a || sat_b))) begin
                        state_d = StDecide;
                    end
                end
                StDecide: begin
                    resp_d   = RESP_W'({resp_q, bit_val});
                    tie_d    = tie_q | (cnt_a == cnt_b);
                    lfsr_d   = CHAL_W'(lfsr_next(32'(lfsr_q), 32'(LFSR_TAP)));
                    idx_d    = idx_q + 1'b1;
                    settle_d = '0;
                    state_d  = (idx_q == IdxLast) ? StDone : StSettle;
                end
                StDone: begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign ro_en_o    = (state_q == StSettle) || (state_q == StMeasure);
    assign busy_o     = busy_q;
    assign ready_o    = ready_q;
    assign response_o = resp_q;
    assign tie_o      = tie_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// Directed bench for ro_puf_engine: stimulus pushes expected results, a monitor
// pops and compares them on each rising ready.
module tb_ro_puf_engine;

    localparam int WIN  = 40;
    localparam int RESP = 8;
    localparam int LAT  = RESP * (WIN + 4) + 1;

    typedef struct {
        logic [7:0] resp;
        logic       tie;
        int         stamp;
        int         lat_lo;
        int         lat_hi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  chall = 8'h00;
    logic [15:0] ro = 16'h0000;
    logic        ro_en, busy, ready, tie;
    logic [7:0]  response;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   tick = 0;
    int   pat = 0;
    exp_t sb[$];

    ro_puf_engine #(
        .N_RO     (16),
        .CHAL_W   (8),
        .RESP_W   (RESP),
        .CNT_W    (3),
        .WIN_CYC  (WIN),
        .LFSR_TAP (8'hB8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .start_i    (start),
        .mode_i     (mode),
        .chall_in_i (chall),
        .ro_in_i    (ro),
        .ro_en_o    (ro_en),
        .busy_o     (busy),
        .ready_o    (ready),
        .response_o (response),
        .tie_o      (tie)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank A waves toggle every 2 cycles, bank B waves every 4 cycles.
    always @(negedge clk) begin
        logic wa, wb;
        tick = tick + 1;
        wa = tick[1];
        wb = tick[2];
        case (pat)
            0:       ro = {{8{wb}}, {8{wa}}};
            1:       ro = {16{wa}};
            2:       ro = {8'h00, {8{wa}}};
            default: ro = 16'h0000;
        endcase
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_run(input logic m, input logic [7:0] c, input int p, output int stamp);
        pat   = p;
        mode  = m;
        chall = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stamp = cyc;
        check("busy_after_start", busy, 1);
        check("ready_drops_after_start", ready, 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
        check("ready_arrives", ready, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_full(input logic m, input logic [7:0] c, input int p, input logic [7:0] r,
                            input logic t, input int lo, input int hi);
        int   st;
        exp_t e;
        start_run(m, c, p, st);
        e = '{resp: r, tie: t, stamp: st, lat_lo: lo, lat_hi: hi};
        sb.push_back(e);
        wait_ready();
    endtask

    initial begin : monitor
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready && !prev) begin
                check("ready_has_expectation", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("response", response, e.resp);
                    check("tie", tie, e.tie);
                    check("busy_low_at_ready", busy, 0);
                    check("ro_en_low_at_ready", ro_en, 0);
                    check_rng("latency", cyc - e.stamp, e.lat_lo, e.lat_hi);
                end
            end
            prev = ready;
        end
    end

    initial begin : stim
        int          st;
        logic [7:0]  gold [8];
        gold = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64};

        repeat (3) @(negedge clk);
        check("rst_outputs", {ro_en, busy, ready, tie, response}, 0);
        check("rst_lfsr", dut.lfsr_q, 0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);

        // Window, zero challenge: lfsr seeds to 1, fast A always beats slow B.
        start_run(1'b1, 8'h00, 0, st);
        check("zero_chall_loads_1", dut.lfsr_q, 1);
        check("ro_en_in_settle", ro_en, 1);
        sb.push_back('{resp: 8'hFF, tie: 1'b0, stamp: st, lat_lo: LAT, lat_hi: LAT});
        wait_ready();

        run_full(1'b1, 8'h3C, 1, 8'h00, 1'b1, LAT, LAT);
        // Race, A saturates long before the window timeout.
        run_full(1'b0, 8'hC3, 2, 8'hFF, 1'b0, RESP * 28 + 1, RESP * (WIN + 3) + 1);
        run_full(1'b0, 8'h77, 3, 8'h00, 1'b1, LAT, LAT);

        // Abort via en during bit 3 measurement.
        start_run(1'b1, 8'h21, 0, st);
        wait_until(st + 3 * (WIN + 4) + 13);
        check("ro_en_mid_measure", ro_en, 1);
        check("partial_response", response, 8'h07);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_response", response, 0);
        check("abort_ro_en", ro_en, 0);
        en = 1'b1;
        @(negedge clk);
        run_full(1'b1, 8'h21, 0, 8'hFF, 1'b0, LAT, LAT);

        // start while busy and during DONE must be ignored.
        start_run(1'b1, 8'h5A, 0, st);
        sb.push_back('{resp: 8'hFF, tie: 1'b0, stamp: st, lat_lo: LAT, lat_hi: LAT});
        wait_until(st + 20);
        mode = 1'b0; chall = 8'h00; pat = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; pat = 0;
        wait_until(st + LAT - 1);
        check("busy_in_done", busy, 1);
        check("ro_en_in_done", ro_en, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("ready_held", ready, 1);
        check("response_held", response, 8'hFF);

        // Golden LFSR sequence from 0x01.
        start_run(1'b1, 8'h01, 0, st);
        check("lfsr_seed", dut.lfsr_q, 8'h01);
        sb.push_back('{resp: 8'hFF, tie: 1'b0, stamp: st, lat_lo: LAT, lat_hi: LAT});
        for (int k = 0; k < 8; k++) begin
            wait_until(st + (k + 1) * (WIN + 4));
            check($sformatf("lfsr_step%0d", k + 1), dut.lfsr_q, gold[k]);
        end
        wait_ready();

        // Reset mid-operation.
        start_run(1'b1, 8'h99, 0, st);
        wait_until(st + 50);
        check("response_before_rst", response, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", {ro_en, busy, ready, tie, response}, 0);
        @(negedge clk);

        // Reset during DONE, with start held: rst dominates.
        start_run(1'b1, 8'h42, 0, st);
        wait_until(st + LAT - 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_done_outputs", {ro_en, busy, ready, tie, response}, 0);
        repeat (3) @(negedge clk);
        check("no_accept_under_rst", busy, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
